// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared constants, pipeline tag type and bank-field helper for the BRAM arbiter
package fb_arb_pkg;

   localparam int NBANK  = 8;
   localparam int BANK_W = $clog2(NBANK);
   localparam int WAW    = 8;
   localparam int DW     = 8;
   localparam int AW     = BANK_W + WAW;
   localparam int RD_LAT = 3;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_VID  = 2'd1,
      SRC_HOST = 2'd2
   } src_t;

   // Bank index lives in the top bits of the logical address.
   function automatic logic [BANK_W-1:0] bank_of(input logic [AW-1:0] addr);
      return addr[AW-1 -: BANK_W];
   endfunction

endpackage

// File: rtl/fb_rr_arb2.sv
// rtl/fb_rr_arb2.sv - two-requester round-robin arbiter with one-bit last-grant memory
module fb_rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   // last_q = 1 means requester 1 won the most recent contested grant.
   logic last_q;
   logic last_d;

   // Lone requester always wins; on contention the side not granted last wins.
   always_comb begin
      gnt_o  = req_i;
      last_d = last_q;
      if (req_i == 2'b11) begin
         gnt_o  = last_q ? 2'b01 : 2'b10;
         last_d = ~last_q;
      end
   end

   // Reset value makes requester 0 (loader) win the first contest.
   always_ff @(posedge clk) begin
      if (reset) last_q <= 1'b1;
      else       last_q <= last_d;
   end

endmodule

// File: rtl/fb_bram_arbiter.sv
// rtl/fb_bram_arbiter.sv - video/host read and loader/host write arbiter for the 8-bank BRAM framebuffer (option: FB_ARB_STARVE_EN)
module fb_bram_arbiter
   import fb_arb_pkg::*;
   #(parameter int STARVE_LIMIT = 64)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vid_en,
   input  logic [AW-1:0]         vid_addr,
   output logic                  vid_valid,
   output logic [DW-1:0]         vid_data,
   input  logic                  ld_req,
   input  logic [AW-1:0]         ld_addr,
   input  logic [DW-1:0]         ld_wdata,
   output logic                  ld_ack,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [AW-1:0]         host_addr,
   input  logic [DW-1:0]         host_wdata,
   output logic                  host_gnt,
   output logic                  host_rvalid,
   output logic [DW-1:0]         host_rdata,
   output logic [WAW-1:0]        bram_rd_addr,
   input  logic [NBANK*DW-1:0]   bram_rd_data,
   output logic [WAW-1:0]        bram_wr_addr,
   output logic [DW-1:0]         bram_wr_data,
   output logic [NBANK-1:0]      bram_wr_strobe,
   output logic [15:0]           vid_steal_cnt
);

   logic             host_rd_req;
   logic             host_rd_gnt;
   logic             vid_issue;
   logic             steal;
   logic [1:0]       wr_req;
   logic [1:0]       wr_gnt;

   logic [WAW-1:0]   rd_addr_q, rd_addr_d;
   logic [WAW-1:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0]    wr_data_q, wr_data_d;
   logic [NBANK-1:0] wr_strobe_q, wr_strobe_d;

   src_t              src_d;
   logic [BANK_W-1:0] bank_d;
   src_t              src_q  [RD_LAT-1];
   logic [BANK_W-1:0] bank_q [RD_LAT-1];
   logic [DW-1:0]     rd_slice;

   logic              vid_valid_q, host_rvalid_q;
   logic [DW-1:0]     vid_data_q, host_rdata_q;

   // Video owns the read port unless a starved host read steals the slot.
   assign host_rd_req = ~reset & host_req & ~host_we;
   assign host_rd_gnt = host_rd_req & (~vid_en | steal);
   assign vid_issue   = ~reset & vid_en & ~steal;

   assign wr_req = {~reset & host_req & host_we, ~reset & ld_req};

   fb_rr_arb2 u_wr_rr (
      .clk   (clk),
      .reset (reset),
      .req_i (wr_req),
      .gnt_o (wr_gnt)
   );

   assign ld_ack   = wr_gnt[0];
   assign host_gnt = host_we ? wr_gnt[1] : host_rd_gnt;

`ifdef FB_ARB_STARVE_EN
   localparam logic [15:0] LIMIT = 16'(STARVE_LIMIT);
   logic [15:0] wait_q, wait_d;
   logic [15:0] steal_q, steal_d;

   assign steal = host_rd_req & vid_en & (wait_q >= LIMIT);

   // Count stalled host-read cycles; count stolen video slots, saturating.
   always_comb begin
      wait_d  = wait_q;
      steal_d = steal_q;
      if (host_gnt)
         wait_d = '0;
      else if (host_rd_req && wait_q < LIMIT)
         wait_d = wait_q + 16'd1;
      if (steal && steal_q != 16'hFFFF)
         steal_d = steal_q + 16'd1;
   end

   // Starvation counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_q  <= '0;
         steal_q <= '0;
      end else begin
         wait_q  <= wait_d;
         steal_q <= steal_d;
      end
   end

   assign vid_steal_cnt = steal_q;
`else
   assign steal         = 1'b0;
   assign vid_steal_cnt = '0;
`endif

   // Select the read issued this cycle and its return tag.
   always_comb begin
      rd_addr_d = rd_addr_q;
      src_d     = SRC_NONE;
      bank_d    = '0;
      if (vid_issue) begin
         rd_addr_d = vid_addr[WAW-1:0];
         src_d     = SRC_VID;
         bank_d    = bank_of(vid_addr);
      end else if (host_rd_gnt) begin
         rd_addr_d = host_addr[WAW-1:0];
         src_d     = SRC_HOST;
         bank_d    = bank_of(host_addr);
      end
   end

   // Select the granted write; strobe is a one-cycle pulse, addr/data hold.
   always_comb begin
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      wr_strobe_d = '0;
      if (wr_gnt[0]) begin
         wr_addr_d   = ld_addr[WAW-1:0];
         wr_data_d   = ld_wdata;
         wr_strobe_d = NBANK'(1) << bank_of(ld_addr);
      end else if (wr_gnt[1]) begin
         wr_addr_d   = host_addr[WAW-1:0];
         wr_data_d   = host_wdata;
         wr_strobe_d = NBANK'(1) << bank_of(host_addr);
      end
   end

   // BRAM-side registers and the tag/bank shift pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_strobe_q <= '0;
         for (int i = 0; i < RD_LAT-1; i++) begin
            src_q[i]  <= SRC_NONE;
            bank_q[i] <= '0;
         end
      end else begin
         rd_addr_q   <= rd_addr_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wr_strobe_q <= wr_strobe_d;
         src_q[0]    <= src_d;
         bank_q[0]   <= bank_d;
         for (int i = 1; i < RD_LAT-1; i++) begin
            src_q[i]  <= src_q[i-1];
            bank_q[i] <= bank_q[i-1];
         end
      end
   end

   assign rd_slice = bram_rd_data[bank_q[RD_LAT-2]*DW +: DW];

   // Capture returned bank data and route it to the tagged requester.
   always_ff @(posedge clk) begin
      if (reset) begin
         vid_valid_q   <= 1'b0;
         host_rvalid_q <= 1'b0;
         vid_data_q    <= '0;
         host_rdata_q  <= '0;
      end else begin
         vid_valid_q   <= (src_q[RD_LAT-2] == SRC_VID);
         host_rvalid_q <= (src_q[RD_LAT-2] == SRC_HOST);
         if (src_q[RD_LAT-2] == SRC_VID)  vid_data_q   <= rd_slice;
         if (src_q[RD_LAT-2] == SRC_HOST) host_rdata_q <= rd_slice;
      end
   end

   assign bram_rd_addr   = rd_addr_q;
   assign bram_wr_addr   = wr_addr_q;
   assign bram_wr_data   = wr_data_q;
   assign bram_wr_strobe = wr_strobe_q;
   assign vid_valid      = vid_valid_q;
   assign vid_data       = vid_data_q;
   assign host_rvalid    = host_rvalid_q;
   assign host_rdata     = host_rdata_q;

endmodule
